// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around mem_arbiter.
// Requests (iREN/dREN/dWEN) are held until the matching 1-cycle hit; RAM strobes are held until ram_ready.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic [DATA_W-1:0] iload;
   logic              ihit;
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic [DATA_W-1:0] dload;
   logic              dhit;
   logic              ram_ren;
   logic              ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_store;
   logic [DATA_W-1:0] ram_load;
   logic              ram_ready;
   logic              busy;
   logic              err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
      output iload, ihit, dload, dhit, ram_ren, ram_wen, ram_addr, ram_store, busy, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
      input  iload, ihit, dload, dhit, ram_ren, ram_wen, ram_addr, ram_store, busy, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with a wait-state watchdog.
// Define ARB_RR_EN for round-robin arbitration; otherwise data requests always win.
module mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WAIT_MAX = 15
) (
   input  logic        CLK,
   input  logic        RST,
   mem_arbiter_if.slave bus,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DBUS = 2'd1,
      IBUS = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(WAIT_MAX + 1);
   // Abort on the cycle whose miss would bring the count to WAIT_MAX.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   state_t            state, state_n;
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
   logic              ren_n, wen_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] store_n, iload_n, dload_n;
   logic              ihit_n, dhit_n, err_n, busy_n;
   logic              d_req, grant_i, grant_d;

   assign d_req = bus.dREN | bus.dWEN;

`ifdef ARB_RR_EN
   logic pri_i, pri_i_n;
   assign grant_i = bus.iREN & (~d_req | pri_i);
`else
   assign grant_i = bus.iREN & ~d_req;
`endif
   assign grant_d = d_req & ~grant_i;

   assign state_dbg = state;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         bus.ram_ren   <= 1'b0;
         bus.ram_wen   <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_store <= '0;
         bus.iload     <= '0;
         bus.dload     <= '0;
         bus.ihit      <= 1'b0;
         bus.dhit      <= 1'b0;
         bus.err       <= 1'b0;
         bus.busy      <= 1'b0;
`ifdef ARB_RR_EN
         pri_i         <= 1'b0;
`endif
      end else begin
         state         <= state_n;
         wait_cnt      <= wait_cnt_n;
         bus.ram_ren   <= ren_n;
         bus.ram_wen   <= wen_n;
         bus.ram_addr  <= addr_n;
         bus.ram_store <= store_n;
         bus.iload     <= iload_n;
         bus.dload     <= dload_n;
         bus.ihit      <= ihit_n;
         bus.dhit      <= dhit_n;
         bus.err       <= err_n;
         bus.busy      <= busy_n;
`ifdef ARB_RR_EN
         pri_i         <= pri_i_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      ren_n      = bus.ram_ren;
      wen_n      = bus.ram_wen;
      addr_n     = bus.ram_addr;
      store_n    = bus.ram_store;
      iload_n    = bus.iload;
      dload_n    = bus.dload;
      ihit_n     = 1'b0;
      dhit_n     = 1'b0;
      err_n      = bus.err;
`ifdef ARB_RR_EN
      pri_i_n    = pri_i;
`endif
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_n    = DBUS;
               wait_cnt_n = '0;
               wen_n      = bus.dWEN;
               ren_n      = ~bus.dWEN;
               addr_n     = bus.daddr;
               store_n    = bus.dstore;
            end else if (grant_i) begin
               state_n    = IBUS;
               wait_cnt_n = '0;
               wen_n      = 1'b0;
               ren_n      = 1'b1;
               addr_n     = bus.iaddr;
               store_n    = '0;
            end
         end
         DBUS, IBUS: begin
            if (bus.ram_ready) begin
               state_n = DONE;
               ren_n   = 1'b0;
               wen_n   = 1'b0;
               if (state == IBUS) begin
                  ihit_n  = 1'b1;
                  iload_n = bus.ram_load;
               end else begin
                  dhit_n  = 1'b1;
                  dload_n = bus.ram_wen ? '0 : bus.ram_load;
               end
            end else if (wait_cnt == CNT_LAST) begin
               // Watchdog abort: still pulse the hit so the requester is released.
               state_n = DONE;
               ren_n   = 1'b0;
               wen_n   = 1'b0;
               err_n   = 1'b1;
               if (state == IBUS) begin
                  ihit_n  = 1'b1;
                  iload_n = '0;
               end else begin
                  dhit_n  = 1'b1;
                  dload_n = '0;
               end
            end else begin
               wait_cnt_n = wait_cnt + CNT_W'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
`ifdef ARB_RR_EN
            pri_i_n = bus.dhit;
`endif
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: RAM-side and hit-side monitors pop expected queues.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DBUS = 2'd1;

  logic clk;
  logic rst;
  logic [1:0] state_dbg;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(15)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave),
    .state_dbg(state_dbg)
  );

  // expected hit: {ihit, dhit, load}; expected RAM access: {wen, ren, addr, store}
  logic [DW+1:0] exp_q[$];
  logic [AW+DW+1:0] ram_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int strobe_cycles = 0;

  int ram_wait = 0;
  logic ram_hang = 1'b0;
  logic [DW-1:0] ram_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // RAM model: ready after ram_wait miss cycles of a held strobe
  initial begin
    int wcnt;
    wcnt = 0;
    bus.ram_ready = 1'b0;
    bus.ram_load = '0;
    forever begin
      @(negedge clk);
      if ((bus.ram_ren || bus.ram_wen) && !ram_hang) begin
        if (wcnt == ram_wait) begin
          bus.ram_ready = 1'b1;
          bus.ram_load = ram_data;
          wcnt = 0;
        end else begin
          bus.ram_ready = 1'b0;
          wcnt++;
        end
      end else begin
        bus.ram_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // hit monitor
  initial begin
    logic [DW+1:0] e;
    forever begin
      @(posedge clk); #1;
      if (bus.ihit || bus.dhit) begin
        if (exp_q.size() == 0) check("spurious_hit", {bus.ihit, bus.dhit}, 0);
        else begin
          e = exp_q.pop_front();
          check("hit_resp", {bus.ihit, bus.dhit, (bus.ihit ? bus.iload : bus.dload)}, e);
        end
      end
    end
  end

  // RAM-side monitor: new strobe must follow IDLE and match the queue, then stay stable
  initial begin
    logic [AW+DW+1:0] cur;
    logic [AW+DW+1:0] act;
    logic prev_strobe;
    logic [1:0] prev_state;
    logic strobe;
    cur = '0;
    prev_strobe = 1'b0;
    prev_state = S_IDLE;
    forever begin
      @(posedge clk); #1;
      strobe = bus.ram_ren | bus.ram_wen;
      act = {bus.ram_wen, bus.ram_ren, bus.ram_addr, bus.ram_store};
      if (strobe) strobe_cycles++;
      if (strobe && !prev_strobe) begin
        check("grant_after_idle", prev_state, S_IDLE);
        if (ram_q.size() == 0) check("spurious_strobe", act, 0);
        else begin
          cur = ram_q.pop_front();
          check("ram_req", act, cur);
        end
      end else if (strobe) begin
        check("ram_hold", act, cur);
      end
      prev_strobe = strobe;
      prev_state = state_dbg;
    end
  end

  task automatic do_req(input logic is_i, input logic ren, input logic wen,
                        input logic [AW-1:0] addr, input logic [DW-1:0] store,
                        input int wait_n, input logic hang, input logic [DW-1:0] load,
                        input logic drop_early, input int exp_edges);
    int edges;
    logic seen;
    logic [DW-1:0] exp_load;
    ram_wait = wait_n;
    ram_hang = hang;
    ram_data = load;
    if (is_i) ram_q.push_back({1'b0, 1'b1, addr, {DW{1'b0}}});
    else ram_q.push_back({wen, ~wen, addr, store});
    exp_load = (hang || (!is_i && wen)) ? '0 : load;
    exp_q.push_back({is_i, ~is_i, exp_load});
    strobe_cycles = 0;
    if (is_i) begin
      bus.iREN = 1'b1; bus.iaddr = addr;
    end else begin
      bus.dREN = ren; bus.dWEN = wen; bus.daddr = addr; bus.dstore = store;
    end
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (bus.ihit || bus.dhit) seen = 1'b1;
      if (drop_early && edges == 1) begin
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.iaddr = 32'h99; bus.daddr = 32'h98; bus.dstore = 32'h97;
      end
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    check("hit_latency", edges, exp_edges);
    check("strobe_cycles", strobe_cycles, hang ? 15 : wait_n + 1);
    @(posedge clk); #1;
    check("post_idle", {state_dbg, bus.busy, bus.ihit, bus.dhit}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int got;
    int cyc;
    rst = 1'b1;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.ram_ren, bus.ram_wen, bus.ram_addr, bus.ram_store, bus.iload,
                            bus.dload, bus.ihit, bus.dhit, bus.busy, bus.err, state_dbg}, 0);
    rst = 1'b0;

    // both requesters held continuously, four grants
    ram_wait = 0;
    ram_data = 32'h1111;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      if (k % 2 == 1) begin
        ram_q.push_back({1'b0, 1'b1, 32'h500, 32'h0});
        exp_q.push_back({1'b1, 1'b0, 32'h1111});
      end else begin
        ram_q.push_back({1'b0, 1'b1, 32'h600, 32'h77});
        exp_q.push_back({1'b0, 1'b1, 32'h1111});
      end
`else
      ram_q.push_back({1'b0, 1'b1, 32'h600, 32'h77});
      exp_q.push_back({1'b0, 1'b1, 32'h1111});
`endif
    end
    bus.iREN = 1'b1; bus.iaddr = 32'h500;
    bus.dREN = 1'b1; bus.daddr = 32'h600; bus.dstore = 32'h77;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ihit || bus.dhit) got++;
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    check("arb_grants", got, 4);
    @(posedge clk); #1;
    check("arb_idle", {state_dbg, bus.busy}, 0);

    // instruction read, two waits
    do_req(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'hDEAD, 1'b0, 4);
    // data write, no wait
    do_req(1'b0, 1'b0, 1'b1, 32'h80, 32'h1234, 0, 1'b0, 32'h5555, 1'b0, 2);
    // data read, one wait
    do_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b0, 32'hCAFE, 1'b0, 3);
    // read and write together act as a write
    do_req(1'b0, 1'b1, 1'b1, 32'h104, 32'hABCD, 0, 1'b0, 32'h6666, 1'b0, 2);
    // request dropped and inputs scrambled after grant
    do_req(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 3, 1'b0, 32'hBEEF, 1'b1, 5);
    check("err_clear", bus.err, 0);

    // watchdog: RAM never ready
    do_req(1'b0, 1'b1, 1'b0, 32'h200, 32'h55, 0, 1'b1, 32'hAAAA, 1'b0, 16);
    check("err_set", bus.err, 1);
    do_req(1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 0, 1'b0, 32'h3333, 1'b0, 2);
    check("err_sticky", bus.err, 1);

    // reset during a write with strobe high
    ram_hang = 1'b1;
    ram_q.push_back({1'b1, 1'b0, 32'h300, 32'h9});
    bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h9;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_state", {state_dbg, bus.ram_wen}, {S_DBUS, 1'b1});
    rst = 1'b1;
    bus.dWEN = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_outputs", {bus.ram_ren, bus.ram_wen, bus.ram_addr, bus.ram_store, bus.iload,
                              bus.dload, bus.ihit, bus.dhit, bus.busy, bus.err, state_dbg}, 0);
    rst = 1'b0;
    ram_hang = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_stay_idle", {state_dbg, bus.busy, bus.err}, 0);

    check("exp_q_empty", exp_q.size(), 0);
    check("ram_q_empty", ram_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
